// File: rtl/bin2bcd_8.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3, 8 iterations).
// Start/done handshake matches the upstream multiplier so its done can drive init.
module bin2bcd_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BIN_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [BCD_W-1:0]   wk_q, wk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   wk_corr;
    logic [BCD_W-1:0]   wk_shift;

    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? 4'(digit + 4'd3) : digit;
    endfunction

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            wk_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            wk_q    <= wk_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (init) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(7)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // One double-dabble iteration: correct all digits from pre-shift values, then shift
    always_comb begin
        wk_corr  = {add3(wk_q[11:8]), add3(wk_q[7:4]), add3(wk_q[3:0])};
        wk_shift = {wk_corr[10:0], sr_q[7]};
    end

    // Datapath updates and registered status outputs
    always_comb begin
        sr_d   = sr_q;
        wk_d   = wk_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (init) begin
                    sr_d  = bin;
                    wk_d  = '0;
                    cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                sr_d  = {sr_q[6:0], 1'b0};
                wk_d  = wk_shift;
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(7)) bcd_d = wk_shift;
            end
            default: ;
        endcase
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_8.sv
// Directed and exhaustive self-checking bench for bin2bcd_8.
module tb_bin2bcd_8;

    logic        clk;
    logic        rst;
    logic        init;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int errors;
    int checks;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs [12];

    bin2bcd_8 dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .bin  (bin),
        .bcd  (bcd),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Pulse init for one cycle, then measure busy length, latency, done width and hold.
    task automatic run_conv(input logic [7:0] b, input logic [11:0] exp_v);
        int n;
        int busy_n;
        @(negedge clk);
        bin  = b;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n = 0;
        busy_n = 0;
        while (!done && n < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        chk("latency", n, 8);
        chk("busy_cycles", busy_n, 8);
        chk("done_high", int'(done), 1);
        chk("bcd_at_done", int'(bcd), int'(exp_v));
        @(negedge clk);
        chk("done_width", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("bcd_hold", int'(bcd), int'(exp_v));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 25) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", int'(busy || done), 0);
    endtask

    initial begin
        int n;
        int last;
        int ndone;
        logic [11:0] r;

        errors = 0;
        checks = 0;
        vecs[0]  = '{8'd225, 12'h225};
        vecs[1]  = '{8'd0,   12'h000};
        vecs[2]  = '{8'd255, 12'h255};
        vecs[3]  = '{8'd99,  12'h099};
        vecs[4]  = '{8'd10,  12'h010};
        vecs[5]  = '{8'd144, 12'h144};
        vecs[6]  = '{8'd36,  12'h036};
        vecs[7]  = '{8'd81,  12'h081};
        vecs[8]  = '{8'd200, 12'h200};
        vecs[9]  = '{8'd1,   12'h001};
        vecs[10] = '{8'd9,   12'h009};
        vecs[11] = '{8'd100, 12'h100};

        rst  = 1'b1;
        init = 1'b0;
        bin  = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_bcd", int'(bcd), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // Directed table
        for (int i = 0; i < 12; i++) run_conv(vecs[i].b, vecs[i].exp_bcd);

        // bin change and stray init during SHIFT
        @(negedge clk);
        bin  = 8'd144;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        bin  = 8'd7;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midshift_latency", n, 8);
        chk("midshift_bcd", int'(bcd), 12'h144);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) ndone++;
        end
        chk("midshift_no_restart", ndone, 0);

        // init held high continuously
        @(negedge clk);
        bin  = 8'd36;
        init = 1'b1;
        last = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                chk("held_bcd", int'(bcd), 12'h036);
                if (last >= 0) chk("held_period", i - last, 10);
                else chk("held_first", i, 8);
                last = i;
                ndone++;
            end
        end
        chk("held_count", ndone, 4);
        init = 1'b0;
        wait_idle();

        // Reset mid-conversion
        run_conv(8'd81, 12'h081);
        @(negedge clk);
        bin  = 8'd200;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bcd", int'(bcd), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_conv(8'd200, 12'h200);

        // rst and init on the same edge
        @(negedge clk);
        rst  = 1'b1;
        init = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
        chk("rst_init_busy", int'(busy), 0);
        @(negedge clk);
        chk("rst_init_busy2", int'(busy), 0);
        chk("rst_init_done", int'(done), 0);

        // Exhaustive sweep against decimal reference
        for (int v = 0; v < 256; v++) begin
            r = ref_bcd(v);
            run_conv(8'(v), r);
            chk("digit_h_le9", int'(bcd[11:8] <= 4'd9), 1);
            chk("digit_t_le9", int'(bcd[7:4] <= 4'd9), 1);
            chk("digit_u_le9", int'(bcd[3:0] <= 4'd9), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
